gb_timer: RTL and testbench

Memory-mapped DIV/TIMA/TMA/TAC timer block that responds to CPU bus accesses at 0xFF04–0xFF07. It sits on the CPU data bus beside `memory` and returns read data through the same address/write-enable/data interface the CPU drives. It keeps the 16-bit system counter that is the source of DIV, increments TIMA on falling edges of a selected counter bit, and pulses a timer interrupt request on TIMA overflow.

---
 rtl/gb_timer_if.sv | 11 +
 rtl/gb_timer.sv | 155 +++++++++++++++
 tb/tb_gb_timer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_timer_if.sv
// CPU bus view of gb_timer: address, write strobe and write data in; read data and select out.
interface gb_timer_if;
    logic [15:0] cpu_addr;
    logic        cpu_wren;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        sel;

    modport master (output cpu_addr, cpu_wren, wr_data, input rd_data, sel);
    modport slave  (input cpu_addr, cpu_wren, wr_data, output rd_data, sel);
endinterface

// File: rtl/gb_timer.sv
// DIV/TIMA/TMA/TAC timer with falling-edge TIMA increment and overflow interrupt.
// TIMER_OVERFLOW_DELAY_EN adds the 4-tick WAIT/RELOAD overflow delay.
module gb_timer #(
    parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick,
    gb_timer_if.slave  bus,
    output logic       irq
);

    logic [15:0] sys_cnt_q, sys_cnt_d;
    logic [7:0]  tima_q, tima_d;
    logic [7:0]  tma_q, tma_d;
    logic [2:0]  tac_q, tac_d;
    logic        sig_q, sig, sel_bit, inc;
    logic        irq_q, irq_d;
    logic [15:0] off;
    logic        sel;
    logic [7:0]  rd_data;
    logic        wr_div, wr_tima, wr_tma, wr_tac;

`ifdef TIMER_OVERFLOW_DELAY_EN
    typedef enum logic [1:0] {StIdle, StWait, StReload} state_e;
    state_e      state_q, state_d;
    logic [1:0]  dly_q, dly_d;
`endif

    // Wrapping subtraction makes the range check a single upper-bits compare.
    assign off     = bus.cpu_addr - BASE_ADDR;
    assign sel     = (off[15:2] == 14'd0);
    assign wr_div  = bus.cpu_wren & sel & (off[1:0] == 2'd0);
    assign wr_tima = bus.cpu_wren & sel & (off[1:0] == 2'd1);
    assign wr_tma  = bus.cpu_wren & sel & (off[1:0] == 2'd2);
    assign wr_tac  = bus.cpu_wren & sel & (off[1:0] == 2'd3);

    always_comb begin
        unique case (tac_q[1:0])
            2'b00: sel_bit = sys_cnt_q[9];
            2'b01: sel_bit = sys_cnt_q[3];
            2'b10: sel_bit = sys_cnt_q[5];
            2'b11: sel_bit = sys_cnt_q[7];
        endcase
    end

    assign sig = tac_q[2] & sel_bit;
    assign inc = sig_q & ~sig;

    always_comb begin
        sys_cnt_d = sys_cnt_q;
        tima_d    = tima_q;
        tma_d     = tma_q;
        tac_d     = tac_q;
        irq_d     = 1'b0;
`ifdef TIMER_OVERFLOW_DELAY_EN
        state_d   = state_q;
        dly_d     = dly_q;
`endif
        if (wr_div) begin
            sys_cnt_d = 16'd0;
        end else if (tick) begin
            sys_cnt_d = sys_cnt_q + 16'd1;
        end
        if (wr_tma) tma_d = bus.wr_data;
        if (wr_tac) tac_d = bus.wr_data[2:0];
`ifdef TIMER_OVERFLOW_DELAY_EN
        unique case (state_q)
            StIdle: begin
                if (wr_tima) begin
                    tima_d = bus.wr_data;
                end else if (inc) begin
                    if (tima_q == 8'hFF) begin
                        tima_d  = 8'h00;
                        state_d = StWait;
                        dly_d   = 2'd3;
                    end else begin
                        tima_d = tima_q + 8'd1;
                    end
                end
            end
            StWait: begin
                if (wr_tima) begin
                    tima_d  = bus.wr_data;
                    state_d = StIdle;
                end else if (tick) begin
                    dly_d = dly_q - 2'd1;
                    if (dly_q == 2'd1) state_d = StReload;
                end
            end
            StReload: begin
                // tma_d so a TMA write on this same edge is the value reloaded
                tima_d  = tma_d;
                irq_d   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
`else
        if (wr_tima) begin
            tima_d = bus.wr_data;
        end else if (inc) begin
            if (tima_q == 8'hFF) begin
                tima_d = tma_q;
                irq_d  = 1'b1;
            end else begin
                tima_d = tima_q + 8'd1;
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sys_cnt_q <= 16'd0;
            tima_q    <= 8'h00;
            tma_q     <= 8'h00;
            tac_q     <= 3'd0;
            sig_q     <= 1'b0;
            irq_q     <= 1'b0;
`ifdef TIMER_OVERFLOW_DELAY_EN
            state_q   <= StIdle;
            dly_q     <= 2'd0;
`endif
        end else begin
            sys_cnt_q <= sys_cnt_d;
            tima_q    <= tima_d;
            tma_q     <= tma_d;
            tac_q     <= tac_d;
            sig_q     <= sig;
            irq_q     <= irq_d;
`ifdef TIMER_OVERFLOW_DELAY_EN
            state_q   <= state_d;
            dly_q     <= dly_d;
`endif
        end
    end

    always_comb begin
        rd_data = 8'hFF;
        if (sel) begin
            unique case (off[1:0])
                2'd0: rd_data = sys_cnt_q[15:8];
                2'd1: rd_data = tima_q;
                2'd2: rd_data = tma_q;
                2'd3: rd_data = {5'b11111, tac_q};
            endcase
        end
    end

    assign bus.rd_data = rd_data;
    assign bus.sel     = sel;
    assign irq         = irq_q;

endmodule

// File: tb/tb_gb_timer.sv
// Scoreboard bench for gb_timer: directed test-plan steps plus random bus traffic vs a reference model.
module tb_gb_timer;

    logic clock = 1'b0;
    logic reset_n;
    logic tick;
    logic irq;

    gb_timer_if bus ();

    gb_timer #(.BASE_ADDR(16'hFF04)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .tick    (tick),
        .bus     (bus),
        .irq     (irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [7:0] rd;
        bit         sel;
        bit         irq;
        bit         hc;
        logic [7:0] cv;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_en = 0;

    // Reference model state
    bit [15:0] m_cnt;
    bit [7:0]  m_tima, m_tma;
    bit [2:0]  m_tac;
    bit        m_sig_q, m_irq, m_reload;
    int        m_wait;

    function automatic int sel_pos(input bit [1:0] t);
        case (t)
            2'b00:   return 9;
            2'b01:   return 3;
            2'b10:   return 5;
            default: return 7;
        endcase
    endfunction

    function automatic bit m_sig();
        return m_tac[2] && m_cnt[sel_pos(m_tac[1:0])];
    endfunction

    function automatic logic [7:0] exp_rd(input logic [15:0] a);
        logic [15:0] off;
        off = a - 16'hFF04;
        case (off)
            16'd0:   return m_cnt[15:8];
            16'd1:   return m_tima;
            16'd2:   return m_tma;
            16'd3:   return {5'b11111, m_tac};
            default: return 8'hFF;
        endcase
    endfunction

    task automatic model_step(input bit rst, input bit tk, input logic [15:0] a, input bit we,
                              input logic [7:0] d);
        logic [15:0] off;
        bit fall, irq_n;
        bit [7:0] tma_old;
        if (!rst) begin
            m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0;
            m_sig_q = 0; m_irq = 0; m_reload = 0; m_wait = 0;
            return;
        end
        off     = a - 16'hFF04;
        fall    = m_sig_q && !m_sig();
        m_sig_q = m_sig();
        tma_old = m_tma;
        irq_n   = 0;
        if (we && off == 0) m_cnt = 0;
        else if (tk) m_cnt = m_cnt + 1;
        if (we && off == 2) m_tma = d;
        if (we && off == 3) m_tac = d[2:0];
        if (m_reload) begin
            m_tima = m_tma;
            irq_n = 1;
            m_reload = 0;
        end else if (m_wait > 0) begin
            if (we && off == 1) begin
                m_tima = d;
                m_wait = 0;
            end else if (tk) begin
                m_wait--;
                if (m_wait == 0) m_reload = 1;
            end
        end else if (we && off == 1) begin
            m_tima = d;
        end else if (fall) begin
            if (m_tima == 8'hFF) begin
`ifdef TIMER_OVERFLOW_DELAY_EN
                m_tima = 0;
                m_wait = 3;
`else
                m_tima = tma_old;
                irq_n = 1;
`endif
            end else begin
                m_tima = m_tima + 1;
            end
        end
        m_irq = irq_n;
    endtask

    task automatic cyc(input bit rst, input bit tk, input logic [15:0] a, input bit we,
                       input logic [7:0] d, input string nm, input bit hc = 0,
                       input logic [7:0] cv = 8'h00);
        exp_t e;
        reset_n      = rst;
        tick         = tk;
        bus.cpu_addr = a;
        bus.cpu_wren = we;
        bus.wr_data  = d;
        if (chk_en) begin
            e.name = nm;
            e.rd   = exp_rd(a);
            e.sel  = ((a - 16'hFF04) < 16'd4);
            e.irq  = m_irq;
            e.hc   = hc;
            e.cv   = cv;
            sb.push_back(e);
        end
        @(posedge clock);
        model_step(rst, tk, a, we, d);
        #1;
    endtask

    task automatic rd(input logic [15:0] a, input string nm, input logic [7:0] cv);
        cyc(1, 0, a, 0, 8'h00, nm, 1, cv);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cyc(1, 0, a, 1, d, "write");
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 1, 16'hFF05, 0, 8'h00, "tick");
    endtask

    task automatic bound_fail(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired, got no event, required event within bound", nm);
    endtask

    // Monitor: compares DUT outputs against the queued expectation for this cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (bus.rd_data !== e.rd) begin
                    miscompares++;
                    $display("FAIL %s rd_data: got %h required %h", e.name, bus.rd_data, e.rd);
                end
                vectors++;
                if (bus.sel !== e.sel) begin
                    miscompares++;
                    $display("FAIL %s sel: got %b required %b", e.name, bus.sel, e.sel);
                end
                vectors++;
                if (irq !== e.irq) begin
                    miscompares++;
                    $display("FAIL %s irq: got %b required %b", e.name, irq, e.irq);
                end
                if (e.hc) begin
                    vectors++;
                    if (bus.rd_data !== e.cv) begin
                        miscompares++;
                        $display("FAIL %s const: got %h required %h", e.name, bus.rd_data, e.cv);
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, required completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int n;
        bit [15:0] a;
        bit [7:0] d;
        bit tk, we, rs;

        // Reset
        cyc(0, 0, 16'hFF04, 0, 8'h00, "reset");
        chk_en = 1;
        cyc(0, 0, 16'hFF04, 0, 8'h00, "reset");
        rd(16'hFF04, "rst_div", 8'h00);
        rd(16'hFF05, "rst_tima", 8'h00);
        rd(16'hFF06, "rst_tma", 8'h00);
        rd(16'hFF07, "rst_tac", 8'hF8);

        // DIV
        for (int i = 0; i < 512; i++) cyc(1, 1, 16'hFF04, 0, 8'h00, "div_run");
        rd(16'hFF04, "div_512", 8'h02);
        cyc(1, 1, 16'hFF04, 1, 8'h5A, "div_wr");
        rd(16'hFF04, "div_clr", 8'h00);
        rd(16'hFF03, "out_of_range", 8'hFF);

        // TIMA counting
        wr(16'hFF07, 8'h05);
        wr(16'hFF05, 8'h00);
        ticks(64);
        rd(16'hFF05, "idle", exp_rd(16'hFF05));
        rd(16'hFF05, "tima_bit3", 8'h04);
        wr(16'hFF07, 8'h04);
        ticks(1024);
        rd(16'hFF05, "idle", exp_rd(16'hFF05));
        rd(16'hFF05, "tima_bit9", 8'h05);

        // Overflow
        wr(16'hFF06, 8'hAB);
        wr(16'hFF05, 8'hFF);
        wr(16'hFF07, 8'h05);
        ticks(24);
        rd(16'hFF05, "ovf_reload", 8'hAB);

`ifdef TIMER_OVERFLOW_DELAY_EN
        // Cancel in WAIT
        wr(16'hFF05, 8'hFF);
        n = 0;
        while (m_wait != 2 && n < 64) begin
            ticks(1);
            n++;
        end
        if (m_wait != 2) bound_fail("cancel_wait");
        cyc(1, 1, 16'hFF05, 1, 8'h10, "cancel_wr");
        ticks(8);
        rd(16'hFF05, "cancel", 8'h10);

        // TMA write during RELOAD
        wr(16'hFF05, 8'hFF);
        n = 0;
        while (!m_reload && n < 64) begin
            ticks(1);
            n++;
        end
        if (!m_reload) bound_fail("reload_wait");
        cyc(1, 0, 16'hFF06, 1, 8'hCD, "reload_tma_wr");
        rd(16'hFF05, "reload_tma", 8'hCD);
`endif

        // Glitch increments from DIV and TAC writes
        wr(16'hFF07, 8'h05);
        n = 0;
        while (!m_cnt[3] && n < 20) begin
            ticks(1);
            n++;
        end
        if (!m_cnt[3]) bound_fail("bit3_wait_a");
        rd(16'hFF05, "idle", exp_rd(16'hFF05));
        wr(16'hFF05, 8'h20);
        wr(16'hFF04, 8'h00);
        rd(16'hFF05, "idle", exp_rd(16'hFF05));
        rd(16'hFF05, "glitch_div", 8'h21);
        n = 0;
        while (!m_cnt[3] && n < 20) begin
            ticks(1);
            n++;
        end
        if (!m_cnt[3]) bound_fail("bit3_wait_b");
        rd(16'hFF05, "idle", exp_rd(16'hFF05));
        wr(16'hFF07, 8'h00);
        rd(16'hFF05, "idle", exp_rd(16'hFF05));
        rd(16'hFF05, "glitch_tac", 8'h22);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rs = ($urandom_range(0, 499) != 0);
            tk = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 15) < 3);
            if (we) begin
                a = 16'hFF02 + 16'($urandom_range(0, 7));
                d = 8'($urandom);
                if (a == 16'hFF05 && $urandom_range(0, 1) == 1) d = 8'hFC + 8'($urandom_range(0, 3));
                if (a == 16'hFF07 && $urandom_range(0, 3) != 0) d = d | 8'h04;
                if (a == 16'hFF04 && $urandom_range(0, 3) != 0) a = 16'hFF05;
            end else begin
                a = 16'hFF00 + 16'($urandom_range(0, 11));
                d = 8'($urandom);
            end
            cyc(rs, tk, a, we, d, "random");
        end

        cyc(1, 0, 16'hFF05, 0, 8'h00, "final");
        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
